// File: rtl/boton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : boton_conditioner
// Description : Push-button input stage. Two-flop synchroniser, debounce FSM,
//               registered level, press/release pulses and auto-repeat train.
// Revision    : 1.0 - initial release
// ============================================================================
module boton_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_raw,
    output logic boton,
    output logic boton_press,
    output logic boton_release,
    output logic boton_repeat,
    output logic boton_pulse
);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               REP_ON    = (REPEAT_EN != 0);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic             boton_q, boton_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             pulse_q, pulse_d;

    logic             s;
    logic [CNT_W-1:0] hold_limit;
    logic             rep_due;

    assign s = sync2_q;

    // Before the first repeat the interval is HOLD, afterwards REPEAT.
    assign hold_limit = rep_phase_q ? REP_LAST : HOLD_LAST;

    // A repeat is only due on a HELD edge that stays HELD; the edge that
    // leaves for RELEASE_CHK leaves hold_cnt untouched so it fires later.
    assign rep_due = (state_q == ST_HELD) && s && (hold_cnt_q == hold_limit);

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= boton_raw;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered-output storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
            boton_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_phase_q <= rep_phase_d;
            boton_q     <= boton_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            pulse_q     <= pulse_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_phase_d = rep_phase_q;
        case (state_q)
            ST_IDLE: begin
                deb_cnt_d = '0;
                if (s) begin
                    state_d   = ST_PRESS_CHK;
                    deb_cnt_d = CNT_ONE;
                end
            end
            ST_PRESS_CHK: begin
                if (!s) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = ST_HELD;
                    deb_cnt_d   = '0;
                    hold_cnt_d  = '0;
                    rep_phase_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d   = ST_RELEASE_CHK;
                    deb_cnt_d = CNT_ONE;
                end else if (rep_due) begin
                    hold_cnt_d  = '0;
                    rep_phase_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            default: begin
                // Release check: hold_cnt is frozen while the release is judged.
                if (s) begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Next values of the registered outputs, derived from the transition taken.
    always_comb begin
        boton_d   = (state_d == ST_HELD) || (state_d == ST_RELEASE_CHK);
        press_d   = (state_q == ST_PRESS_CHK) && (state_d == ST_HELD);
        release_d = (state_q == ST_RELEASE_CHK) && (state_d == ST_IDLE);
        repeat_d  = REP_ON && rep_due;
        pulse_d   = press_d | repeat_d;
    end

    assign boton         = boton_q;
    assign boton_press   = press_q;
    assign boton_release = release_q;
    assign boton_repeat  = repeat_q;
    assign boton_pulse   = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_boton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_boton_conditioner
// Description : Self-checking bench for boton_conditioner. Two instances
//               (auto-repeat on / off) share one stimulus stream and are
//               compared every cycle against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boton_conditioner;

    localparam int D = 4;
    localparam int H = 8;
    localparam int R = 4;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic boton_raw = 1'b0;

    logic a_boton, a_press, a_release, a_repeat, a_pulse;
    logic b_boton, b_press, b_release, b_repeat, b_pulse;

    always #5 clk = ~clk;

    boton_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
        .REPEAT_EN(1), .CNT_W(8)
    ) u_dut_rep (
        .clk(clk), .reset(reset), .boton_raw(boton_raw),
        .boton(a_boton), .boton_press(a_press), .boton_release(a_release),
        .boton_repeat(a_repeat), .boton_pulse(a_pulse)
    );

    boton_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
        .REPEAT_EN(0), .CNT_W(8)
    ) u_dut_norep (
        .clk(clk), .reset(reset), .boton_raw(boton_raw),
        .boton(b_boton), .boton_press(b_press), .boton_release(b_release),
        .boton_repeat(b_repeat), .boton_pulse(b_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw history, debounced level, length of the current
    // run of synchronised samples disagreeing with the level, and the number
    // of counted held cycles since the accepted press.
    bit m_h1, m_h2, m_lvl;
    int m_run, m_act;
    bit e_press, e_rel, e_rep;

    int cnt_pulse_a, cnt_pulse_b, cnt_rep_b, cnt_rel_a, cnt_press_a;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_lvl = 0; m_run = 0; m_act = 0;
        e_press = 0; e_rel = 0; e_rep = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit s;
        s = m_h2;
        m_h2 = m_h1;
        m_h1 = raw;
        e_press = 0; e_rel = 0; e_rep = 0;
        if (!m_lvl) begin
            if (s) begin
                m_run++;
                if (m_run == D) begin
                    m_lvl = 1; m_run = 0; m_act = 0; e_press = 1;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (s) begin
                // Only a cycle that was already settled as held advances time.
                if (m_run == 0) begin
                    m_act++;
                    if (m_act >= H && ((m_act - H) % R) == 0) e_rep = 1;
                end
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == D) begin
                    m_lvl = 0; m_run = 0; e_rel = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_boton",   a_boton,   m_lvl);
        chk("a_press",   a_press,   e_press);
        chk("a_release", a_release, e_rel);
        chk("a_repeat",  a_repeat,  e_rep);
        chk("a_pulse",   a_pulse,   e_press | e_rep);
        chk("b_boton",   b_boton,   m_lvl);
        chk("b_press",   b_press,   e_press);
        chk("b_release", b_release, e_rel);
        chk("b_repeat",  b_repeat,  1'b0);
        chk("b_pulse",   b_pulse,   e_press);
    endtask

    task automatic clear_counts();
        cnt_pulse_a = 0; cnt_pulse_b = 0; cnt_rep_b = 0;
        cnt_rel_a = 0; cnt_press_a = 0;
    endtask

    task automatic step(input bit v);
        @(negedge clk);
        boton_raw = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_all();
        cnt_pulse_a += int'(a_pulse);
        cnt_pulse_b += int'(b_pulse);
        cnt_rep_b   += int'(b_repeat);
        cnt_rel_a   += int'(a_release);
        cnt_press_a += int'(a_press);
    endtask

    // Holds raw high, returns the step index (0 = first sampled) of the press.
    task automatic press_latency(input int budget, output int k);
        k = -1;
        for (int i = 0; i < budget; i++) begin
            step(1'b1);
            if (a_press === 1'b1 && k < 0) k = i;
        end
    endtask

    initial begin
        int k;
        int len;
        bit v;

        // Reset state
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b1;

        // Clean press: latency D+1 from the first sampling edge
        repeat (3) step(1'b0);
        press_latency(12, k);
        chk_int("press_latency", k, D + 1);
        chk_int("press_count_a", cnt_press_a, 1);
        chk_int("pulse_eq_press", cnt_pulse_b, 1);
        repeat (10) step(1'b0);

        // Short bounce: no output activity
        clear_counts();
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        repeat (8) step(1'b0);
        chk_int("bounce_pulses", cnt_pulse_a, 0);
        chk_int("bounce_presses", cnt_press_a, 0);

        // Release glitch inside RELEASE_CHK, then one clean release
        repeat (10) step(1'b1);
        clear_counts();
        step(1'b0); step(1'b0); step(1'b1);
        repeat (10) step(1'b0);
        chk_int("glitch_release_count", cnt_rel_a, 1);

        // Auto-repeat: held 30 cycles
        clear_counts();
        repeat (30) step(1'b1);
        repeat (10) step(1'b0);
        chk_int("repeat_pulses_en", cnt_pulse_a, 6);
        chk_int("repeat_pulses_dis", cnt_pulse_b, 1);
        chk_int("repeat_count_dis", cnt_rep_b, 0);

        // Asynchronous reset while held, button still held at release
        repeat (12) step(1'b1);
        chk("held_before_reset", a_boton, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b1;
        clear_counts();
        press_latency(12, k);
        chk_int("press_after_reset", k, D + 1);
        repeat (10) step(1'b0);

        // Downstream sequence FSM: three clean presses advance three states
        clear_counts();
        repeat (3) begin
            repeat (8) step(1'b1);
            repeat (8) step(1'b0);
        end
        chk_int("fsm_advances", cnt_pulse_a, 3);

        // Randomised segments, including bounces and long holds
        for (int seg = 0; seg < 200; seg++) begin
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(10, 40));
            else                           len = int'($urandom_range(1, 6));
            repeat (len) step(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
